// File: rtl/dmem_responder_if.sv
// Load/store data-memory request/response bus.
// master = load/store stage, slave = memory responder.
interface dmem_responder_if #(
    parameter int unsigned XLEN = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [XLEN/8-1:0] req_wmask;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask,
        output resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask,
        input  resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data memory responder: one outstanding request,
// byte-masked stores, range-checked addresses.
module dmem_responder #(
    parameter int unsigned     XLEN    = 64,
    parameter int unsigned     DEPTH   = 1024,
    parameter logic [XLEN-1:0] BASE    = 'h8000_0000,
    parameter int unsigned     LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_responder_if.slave  bus
);
    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam int unsigned NB   = XLEN / 8;
    localparam logic [XLEN-1:0] LIMIT = BASE + XLEN'(DEPTH * 8);
    localparam logic [3:0] CNT_INIT =
        (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wen_q, wen_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]     wmask_q, wmask_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [XLEN-1:0]   mem [DEPTH];

    logic              accept;
    logic              enter_resp;
    logic              src_wen;
    logic [XLEN-1:0]   src_addr;
    logic [XLEN-1:0]   src_wdata;
    logic [NB-1:0]     src_wmask;
    logic              in_range;
    logic [XLEN-1:0]   offset;
    logic [IDXW-1:0]   idx;
    logic              mem_we;

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    // Access source: live bus fields on the accept edge, captured copy afterwards.
    always_comb begin
        accept     = bus.req_valid && (state_q == IDLE);
        enter_resp = (accept && (LATENCY == 1))
                  || ((state_q == WAIT) && (cnt_q == 4'd0));
        src_wen    = (state_q == IDLE) ? bus.req_wen   : wen_q;
        src_addr   = (state_q == IDLE) ? bus.req_addr  : addr_q;
        src_wdata  = (state_q == IDLE) ? bus.req_wdata : wdata_q;
        src_wmask  = (state_q == IDLE) ? bus.req_wmask : wmask_q;
        in_range   = (src_addr >= BASE) && (src_addr < LIMIT);
        offset     = src_addr - BASE;
        idx        = IDXW'(offset >> 3);
        mem_we     = enter_resp && src_wen && in_range;
    end

    // Next-state, counter, capture and response register logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        valid_d = valid_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    wen_d   = bus.req_wen;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    wmask_d = bus.req_wmask;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (enter_resp) begin
            valid_d = 1'b1;
            err_d   = !in_range;
            rdata_d = (in_range && !src_wen) ? mem[idx] : '0;
        end
    end

    // State and capture registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage array keeps its contents across reset; byte-lane writes.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (mem_we && src_wmask[b]) begin
                mem[idx][b*8 +: 8] <= src_wdata[b*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table, scoreboard, latency sweep,
// backpressure and reset-in-WAIT sequences.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        t_valid, t_wen, t_rready;
    logic [63:0] t_addr, t_wdata;
    logic [7:0]  t_wmask;
    int          sel;

    logic        o_ready, o_rvalid, o_err;
    logic [63:0] o_rdata;

    int n_chk = 0;
    int n_fail = 0;

    dmem_responder_if #(.XLEN(64)) b1 ();
    dmem_responder_if #(.XLEN(64)) b2 ();
    dmem_responder_if #(.XLEN(64)) b15 ();

    dmem_responder #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave));
    dmem_responder #(.LATENCY(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .bus(b2.slave));
    dmem_responder #(.LATENCY(15)) u_l15 (
        .clk(clk), .rst_n(rst_n), .bus(b15.slave));

    assign b1.req_valid  = t_valid && (sel == 1);
    assign b1.req_wen    = t_wen;
    assign b1.req_addr   = t_addr;
    assign b1.req_wdata  = t_wdata;
    assign b1.req_wmask  = t_wmask;
    assign b1.resp_ready = t_rready;

    assign b2.req_valid  = t_valid && (sel == 2);
    assign b2.req_wen    = t_wen;
    assign b2.req_addr   = t_addr;
    assign b2.req_wdata  = t_wdata;
    assign b2.req_wmask  = t_wmask;
    assign b2.resp_ready = t_rready;

    assign b15.req_valid  = t_valid && (sel == 15);
    assign b15.req_wen    = t_wen;
    assign b15.req_addr   = t_addr;
    assign b15.req_wdata  = t_wdata;
    assign b15.req_wmask  = t_wmask;
    assign b15.resp_ready = t_rready;

    // Observe the instance under test.
    always_comb begin
        case (sel)
            1: begin
                o_ready = b1.req_ready;  o_rvalid = b1.resp_valid;
                o_rdata = b1.resp_rdata; o_err    = b1.resp_err;
            end
            15: begin
                o_ready = b15.req_ready;  o_rvalid = b15.resp_valid;
                o_rdata = b15.resp_rdata; o_err    = b15.resp_err;
            end
            default: begin
                o_ready = b2.req_ready;  o_rvalid = b2.resp_valid;
                o_rdata = b2.resp_rdata; o_err    = b2.resp_err;
            end
        endcase
    end

    typedef struct {
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  mask;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic txn(input logic wen, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [7:0] mask,
                       input logic [63:0] er, input logic ee,
                       input int lat, input int hold);
        int n;
        exp_t e;
        logic [63:0] r0;
        logic e0;
        @(negedge clk);
        chk("req_ready_idle", 64'(o_ready), 64'd1);
        t_valid = 1'b1;
        t_wen   = wen;
        t_addr  = addr;
        t_wdata = wdata;
        t_wmask = mask;
        sb.push_back('{er, ee});
        @(posedge clk);
        #1;
        t_valid = 1'b0;
        t_wen   = ~wen;
        t_addr  = '1;
        t_wdata = '1;
        t_wmask = '1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_rvalid && n < 40);
        chk("latency", 64'(n), 64'(lat));
        r0 = o_rdata;
        e0 = o_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(o_rvalid), 64'd1);
            chk("hold_rdata", o_rdata, r0);
            chk("hold_err", 64'(o_err), 64'(e0));
            chk("hold_req_ready", 64'(o_ready), 64'd0);
        end
        t_rready = 1'b1;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk("resp_rdata", o_rdata, e.rdata);
            chk("resp_err", 64'(o_err), 64'(e.err));
        end
        @(posedge clk);
        #1;
        t_rready = 1'b0;
        chk("post_valid", 64'(o_rvalid), 64'd0);
        chk("post_rdata", o_rdata, 64'd0);
        chk("post_err", 64'(o_err), 64'd0);
        chk("post_req_ready", 64'(o_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1, 64'h8000_0010, 64'h1122334455667788, 8'hFF, 64'h0, 0};
        vecs[1]  = '{0, 64'h8000_0010, 64'h0, 8'h00, 64'h1122334455667788, 0};
        vecs[2]  = '{1, 64'h8000_0010, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0, 0};
        vecs[3]  = '{0, 64'h8000_0010, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 0};
        vecs[4]  = '{1, 64'h8000_1FF8, 64'h0BADF00DCAFEBABE, 8'hFF, 64'h0, 0};
        vecs[5]  = '{0, 64'h7FFF_FFF8, 64'h0, 8'h00, 64'h0, 1};
        vecs[6]  = '{1, 64'h8000_2000, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1};
        vecs[7]  = '{0, 64'h8000_1FF8, 64'h0, 8'h00, 64'h0BADF00DCAFEBABE, 0};
        vecs[8]  = '{1, 64'h8000_0018, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 0};
        vecs[9]  = '{1, 64'h8000_0018, 64'hFFFFFFFFFFFFFFFF, 8'h00, 64'h0, 0};
        vecs[10] = '{1, 64'h8000_001B, 64'hFFFFFFFFFFFFFFFF, 8'h81, 64'h0, 0};
        vecs[11] = '{0, 64'h8000_001C, 64'h0, 8'h00, 64'hFF23456789ABCDFF, 0};
        vecs[12] = '{0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 8'h00, 64'h0, 1};

        sel      = 2;
        t_valid  = 1'b0;
        t_wen    = 1'b0;
        t_addr   = '0;
        t_wdata  = '0;
        t_wmask  = '0;
        t_rready = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(o_rvalid), 64'd0);
        chk("rst_rdata", o_rdata, 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_req_ready", 64'(o_ready), 64'd1);

        for (int i = 0; i < 13; i++) begin
            txn(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].mask,
                vecs[i].exp_rdata, vecs[i].exp_err, 2, 0);
        end

        // Backpressure: response held for five stalled cycles.
        txn(0, 64'h8000_0010, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 0, 2, 5);

        // Reset while a store waits: the store must be dropped.
        txn(1, 64'h8000_0020, 64'h0000_0000_0000_1234, 8'hFF, 64'h0, 0, 2, 0);
        @(negedge clk);
        t_valid = 1'b1;
        t_wen   = 1'b1;
        t_addr  = 64'h8000_0020;
        t_wdata = 64'h0000_0000_0000_DEAD;
        t_wmask = 8'hFF;
        @(posedge clk);
        #1;
        t_valid = 1'b0;
        chk("wait_req_ready", 64'(o_ready), 64'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_wait_valid", 64'(o_rvalid), 64'd0);
        chk("rst_wait_rdata", o_rdata, 64'd0);
        chk("rst_wait_err", 64'(o_err), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        txn(0, 64'h8000_0020, 64'h0, 8'h00, 64'h0000_0000_0000_1234, 0, 2, 0);

        // Latency sweep.
        sel = 1;
        txn(1, 64'h8000_0010, 64'h1122334455667788, 8'hFF, 64'h0, 0, 1, 0);
        txn(0, 64'h8000_0010, 64'h0, 8'h00, 64'h1122334455667788, 0, 1, 0);
        sel = 15;
        txn(1, 64'h8000_0010, 64'h1122334455667788, 8'hFF, 64'h0, 0, 15, 0);
        txn(0, 64'h8000_0010, 64'h0, 8'h00, 64'h1122334455667788, 0, 15, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
